// File: rtl/pc_sequenciador_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequenciador_pkg
// Shared CPU definitions used by the program counter sequencer: the FSM state
// encoding, the default PC width, and the default interrupt entry address.
// No ports; import with "import pc_sequenciador_pkg::*;".
// -----------------------------------------------------------------------------
package pc_sequenciador_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 26;

  localparam logic [25:0] DEFAULT_INT_VEC = 26'h0000100;

  // BOOT: PC parked after reset/restart; RUN: normal fetch; HALTED: frozen
  // until resume; ISR: like RUN but with interrupts masked.
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    ISR    = 2'd3
  } pcState_t;

  // The fetch stage may only use pcAtual in the two "executing" states.
  function automatic logic isFetchState(input pcState_t s);
    return (s == RUN) || (s == ISR);
  endfunction

endpackage

// File: rtl/pc_sequenciador_prioridade_restart.sv
// -----------------------------------------------------------------------------
// pc_prioridade_restart
// Lowest-index priority encoder over the restart request vector.
// Ports:
//   req_i  [N-1:0]  restart request bits
//   any_o           at least one request bit set
//   idx_o  [IW-1:0] index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module pc_prioridade_restart #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the highest index down so the last hit written is the lowest
  // set index, which is the source that wins when several restart together.
  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pc_sequenciador.sv
// -----------------------------------------------------------------------------
// pc_sequenciador
// Program counter sequencer with restart sources, one interrupt level, halt
// and resume, stall, jump and sequential increment. Every output is a flop.
// Ports:
//   clock        rising-edge clock
//   pc_reset     asynchronous active-high reset
//   restart_req  [N_SRC] synchronous restart requests (lowest index wins)
//   irq          level interrupt request (taken only in RUN)
//   eret         return from interrupt (only meaningful in ISR)
//   halt/resume  enter / leave the HALTED state
//   stall        hold the PC
//   jump         load endereco
//   endereco     jump/branch target
//   pcAtual      current PC
//   pc_valid     pcAtual may be fetched
//   epc          saved return address
//   in_isr       interrupt is being serviced
//   restart_src  index of the last restart source taken
// -----------------------------------------------------------------------------
module pc_sequenciador
  import pc_sequenciador_pkg::*;
#(
  parameter int                              ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int                              N_SRC        = 3,
  parameter logic [N_SRC*ADDR_WIDTH-1:0]     RESTART_VECS = '0,
  parameter logic [ADDR_WIDTH-1:0]           INT_VEC      = ADDR_WIDTH'(DEFAULT_INT_VEC),
  parameter int unsigned                     INC          = 1
) (
  input  logic                                        clock,
  input  logic                                        pc_reset,
  input  logic [N_SRC-1:0]                            restart_req,
  input  logic                                        irq,
  input  logic                                        eret,
  input  logic                                        halt,
  input  logic                                        resume,
  input  logic                                        stall,
  input  logic                                        jump,
  input  logic [ADDR_WIDTH-1:0]                       endereco,
  output logic [ADDR_WIDTH-1:0]                       pcAtual,
  output logic                                        pc_valid,
  output logic [ADDR_WIDTH-1:0]                       epc,
  output logic                                        in_isr,
  output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] restart_src
);

  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  pcState_t              state_q, state_d;
  pcState_t              haltRet_q, haltRet_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic                  pcValid_q;
  logic                  inIsr_q;

  logic                  restartAny;
  logic [SRC_W-1:0]      restartIdx;
  logic [ADDR_WIDTH-1:0] seqNext;
  logic [ADDR_WIDTH-1:0] restartVec [N_SRC];

  pc_prioridade_restart #(
    .N  (N_SRC),
    .IW (SRC_W)
  ) uPrioridade (
    .req_i (restart_req),
    .any_o (restartAny),
    .idx_o (restartIdx)
  );

  // Unpack the flat restart vector parameter so each source's address can be
  // picked with a plain array index.
  for (genvar g = 0; g < N_SRC; g++) begin : gVec
    assign restartVec[g] = RESTART_VECS[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Next-state decision. seqNext is the address a normal executing cycle would
  // load (stall beats jump beats increment); it is also what an interrupt
  // saves into epc, so returning resumes exactly where execution would have
  // gone. A restart overrides everything in every state. In RUN an interrupt
  // outranks halt; eret is only honoured in ISR and otherwise falls through
  // to the lower-priority actions. HALTED ignores everything but resume.
  always_comb begin
    seqNext   = stall ? pc_q : (jump ? endereco : pc_q + ADDR_WIDTH'(INC));
    state_d   = state_q;
    haltRet_d = haltRet_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    src_d     = src_q;
    if (restartAny) begin
      pc_d    = restartVec[restartIdx];
      src_d   = restartIdx;
      epc_d   = '0;
      state_d = BOOT;
    end else begin
      case (state_q)
        BOOT: begin
          state_d = RUN;
        end
        HALTED: begin
          if (resume) begin
            state_d = haltRet_q;
          end
        end
        RUN: begin
          if (irq) begin
            epc_d   = seqNext;
            pc_d    = INT_VEC;
            state_d = ISR;
          end else if (halt) begin
            haltRet_d = RUN;
            state_d   = HALTED;
          end else begin
            pc_d = seqNext;
          end
        end
        ISR: begin
          if (eret) begin
            pc_d    = epc_q;
            state_d = RUN;
          end else if (halt) begin
            haltRet_d = ISR;
            state_d   = HALTED;
          end else begin
            pc_d = seqNext;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // State and output registers. pc_valid and in_isr are computed from the
  // next state so they line up with the PC they describe, while still being
  // driven straight from flops. Reset throws away any ISR/HALTED context.
  always_ff @(posedge clock or posedge pc_reset) begin
    if (pc_reset) begin
      state_q   <= BOOT;
      haltRet_q <= RUN;
      pc_q      <= '0;
      epc_q     <= '0;
      src_q     <= '0;
      pcValid_q <= 1'b0;
      inIsr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      haltRet_q <= haltRet_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      src_q     <= src_d;
      pcValid_q <= isFetchState(state_d);
      inIsr_q   <= (state_d == ISR);
    end
  end

  assign pcAtual     = pc_q;
  assign pc_valid    = pcValid_q;
  assign epc         = epc_q;
  assign in_isr      = inIsr_q;
  assign restart_src = src_q;

endmodule

// File: doc/pc_sequenciador.md
PC_SEQUENCIADOR -- requirements
Module: pc_sequenciador

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 26, PC width in bits.
REQ-002 SHALL have parameter N_SRC, default 3, number of restart sources (pc, bios, disk ...).
REQ-003 SHALL have parameter RESTART_VECS, default all zero, N_SRC*ADDR_WIDTH packed restart vectors; slice i = vector of source i.
REQ-004 SHALL have parameter INT_VEC, default 26'h0000100, interrupt entry address.
REQ-005 SHALL have parameter INC, default 1, sequential increment.
REQ-006 SHALL have ports: clock  in  1  single clock, rising edge; pc_reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: restart_req  in  N_SRC  synchronous restart requests; irq  in  1  interrupt request, level.
REQ-008 SHALL have ports: eret  in  1  return from interrupt; halt  in  1  halt request; resume  in  1  leave HALTED.
REQ-009 SHALL have ports: stall  in  1  hold PC; jump  in  1  load endereco; endereco  in  ADDR_WIDTH  jump/branch target.
REQ-010 SHALL have ports: pcAtual  out  ADDR_WIDTH  current PC; pc_valid  out  1  pcAtual is fetchable; epc  out  ADDR_WIDTH  saved return address; in_isr  out  1  interrupt being serviced; restart_src  out  clog2(N_SRC)  last restart source taken.

Function
REQ-011 SHALL implement FSM states BOOT, RUN, HALTED, ISR; ISR behaves as RUN except irq is masked.
REQ-012 SHALL, in BOOT, hold pcAtual, drive pc_valid=0, and go to RUN on the next edge.
REQ-013 SHALL evaluate one action per rising edge, in fixed priority: restart_req > irq > eret > halt > stall > jump > increment.
REQ-014 SHALL, on any restart_req bit set (any state), load the vector of the lowest set index, record that index in restart_src, clear epc, and enter BOOT.
REQ-015 SHALL, on irq=1 in RUN (not ISR/HALTED/BOOT), save to epc the address that would otherwise have been loaded this cycle (next sequential or jump target; held PC if stall=1), load INT_VEC, and enter ISR.
REQ-016 SHALL, on eret=1 in ISR, load epc and return to RUN; eret outside ISR SHALL be ignored (lower-priority action taken).
REQ-017 SHALL, on halt=1 in RUN or ISR, hold pcAtual, enter HALTED, and remember the originating state.
REQ-018 SHALL, in HALTED, hold pcAtual with pc_valid=0, ignore irq/eret/jump/stall, and on resume=1 return to the remembered state with pc_valid=1 next cycle.
REQ-019 SHALL, on stall=1, hold pcAtual; on jump=1, load endereco; otherwise load pcAtual+INC.
REQ-020 SHALL compute all address arithmetic modulo 2^ADDR_WIDTH (all-ones + 1 wraps to 0, no flag).
REQ-021 SHALL drive pc_valid=1 in RUN and ISR, 0 in BOOT and HALTED; in_isr=1 only in ISR.
REQ-022 SHALL have zero combinational path from inputs to pcAtual; all outputs registered.

Reset
REQ-023 SHALL, while pc_reset=1, asynchronously force pcAtual=0, epc=0, restart_src=0, state=BOOT, pc_valid=0, in_isr=0, independent of clock.
REQ-024 SHALL, on reset release, leave BOOT at the first rising edge and fetch from 0 with pc_valid=1 on the second edge.
REQ-025 SHALL discard any in-progress ISR/HALTED context when pc_reset asserts mid-operation.

Structure
REQ-026 SHALL place the FSM state encoding and the default INT_VEC constant in the shared CPU package.
REQ-027 SHALL use one sub-module, pc_prioridade_restart, a parametrised lowest-index priority encoder over restart_req.

Verification
REQ-028 Reset pulse mid-cycle with pcAtual=26'h00000A5 -> pcAtual=0 immediately, pc_valid=0, then 0,1,2 with pc_valid=1 from second edge.
REQ-029 restart_req=3'b110, RESTART_VECS slice1=26'h0000200 -> pcAtual=26'h0000200, restart_src=1, BOOT one cycle.
REQ-030 PC=26'h0000040, irq=1, jump=1, endereco=26'h0000080 -> epc=26'h0000080, pcAtual=INT_VEC, in_isr=1; second irq ignored; eret -> pcAtual=26'h0000080, in_isr=0.
REQ-031 PC=26'h3FFFFFF, no control -> pcAtual=0 next edge.
REQ-032 halt in ISR, then irq and jump asserted, then resume -> PC held throughout with pc_valid=0, returns to ISR, increments next cycle.
REQ-033 stall=1 and jump=1 together at PC=26'h0000010 -> pcAtual stays 26'h0000010.
